mem_req_arbiter: RTL and testbench

//  Shares the single blocking memory-command port (the MemMapCntr-side ready/valid/addr/wen/wdata/rdata

---
 rtl/memarb_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/mem_req_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_req_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/memarb_pkg.sv
// Shared types and requester indices for the memory-command arbiter.
package memarb_pkg;

  typedef enum logic [0:0] {
    IDLE,
    WAIT_RESP
  } arb_state_t;

  localparam int unsigned REQ_IFETCH = 0;
  localparam int unsigned REQ_DATA   = 1;
  localparam int unsigned REQ_DEBUG  = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: first asserted request at or after ptr (wrapping), or lowest index when fixed.
module rr_arbiter #(
  parameter int unsigned N = 3,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  input  logic            fixed,
  output logic [IdxW-1:0] gnt,
  output logic            any
);

  logic [IdxW-1:0]  ptr_eff;
  logic [2*N-1:0]   req_dbl;
  logic [2*N-1:0]   req_rot;
  int unsigned      sum;

  always_comb begin
    ptr_eff = fixed ? '0 : ptr;
    // Rotating a doubled vector right by ptr puts the scan start at bit 0.
    req_dbl = {req, req};
    req_rot = req_dbl >> ptr_eff;
    gnt     = '0;
    any     = 1'b0;
    sum     = 0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!any && req_rot[j]) begin
        any = 1'b1;
        sum = 32'(ptr_eff) + j;
        if (sum >= N) sum = sum - N;
        gnt = IdxW'(sum);
      end
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one blocking memory-command port between NREQ requesters with a single outstanding read,
// response routing to the owner and a watchdog for lost read responses.
module mem_req_arbiter
  import memarb_pkg::*;
#(
  parameter int unsigned NREQ       = 3,
  parameter int unsigned TIMEOUT    = 1024,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               halt,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*32-1:0] req_addr,
  input  logic [NREQ-1:0]    req_wen,
  input  logic [NREQ*32-1:0] req_wdata,
  output logic [NREQ-1:0]    resp_valid,
  output logic [31:0]        resp_rdata,
  output logic               resp_err,
  input  logic               mem_req_ready,
  output logic               mem_req_valid,
  output logic [31:0]        mem_req_addr,
  output logic               mem_req_wen,
  output logic [31:0]        mem_req_wdata,
  input  logic               mem_resp_valid,
  input  logic [31:0]        mem_resp_rdata
);

  localparam int unsigned IdxW      = $clog2(NREQ);
  localparam int unsigned WdogW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit          TimeoutEn = (TIMEOUT != 0);
  localparam logic [WdogW-1:0] WdogLast = WdogW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [WdogW-1:0] WdogMax  = WdogW'(TIMEOUT);

  arb_state_t       state_q, state_d;
  logic [IdxW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]  owner_q, owner_d;
  logic [WdogW-1:0] wdog_q, wdog_d;
  logic [NREQ-1:0]  resp_valid_q, resp_valid_d;
  logic             resp_err_q, resp_err_d;
  logic [31:0]      resp_rdata_q, resp_rdata_d;

  logic [IdxW-1:0]  gnt;
  logic             any;
  logic             handshake;

  rr_arbiter #(
    .N(NREQ)
  ) u_rr_arbiter (
    .req  (req_valid),
    .ptr  (rr_ptr_q),
    .fixed(FIXED_PRIO),
    .gnt  (gnt),
    .any  (any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      wdog_q       <= '0;
      resp_valid_q <= '0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      wdog_q       <= wdog_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign handshake = mem_req_valid & mem_req_ready;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    wdog_d       = wdog_q;
    resp_valid_d = '0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (handshake) begin
          if (!FIXED_PRIO) begin
            rr_ptr_d = (32'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
          end
          // Writes retire at the handshake; only reads wait for data.
          if (!mem_req_wen) begin
            owner_d = gnt;
            wdog_d  = '0;
            state_d = WAIT_RESP;
          end
        end
      end
      WAIT_RESP: begin
        if (wdog_q != WdogMax) wdog_d = wdog_q + 1'b1;
        if (mem_resp_valid) begin
          resp_valid_d[owner_q] = 1'b1;
          resp_rdata_d          = mem_resp_rdata;
          state_d               = IDLE;
        end else if (TimeoutEn && wdog_q == WdogLast) begin
          resp_valid_d[owner_q] = 1'b1;
          resp_err_d            = 1'b1;
          resp_rdata_d          = '0;
          state_d               = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req_valid = 1'b0;
    req_ready     = '0;
    mem_req_addr  = '0;
    mem_req_wen   = 1'b0;
    mem_req_wdata = '0;
    // Reset also masks the command so nothing is offered while rst is held.
    if (!rst && state_q == IDLE) mem_req_valid = any & ~halt;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IdxW'(i) == gnt) begin
        mem_req_addr  = req_addr[32*i +: 32];
        mem_req_wen   = req_wen[i];
        mem_req_wdata = req_wdata[32*i +: 32];
        req_ready[i]  = mem_req_valid & mem_req_ready;
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench: table-driven grant vectors plus scripted read/write/timeout/halt sequences,
// with grant and response scoreboards fed at stimulus time.
module tb_mem_req_arbiter;
  import memarb_pkg::*;

  logic        clk = 1'b0;
  logic        rst, halt;
  logic [2:0]  req_valid, req_ready, req_wen, resp_valid;
  logic [95:0] req_addr, req_wdata;
  logic [31:0] resp_rdata, mem_req_addr, mem_req_wdata, mem_resp_rdata;
  logic        resp_err, mem_req_ready, mem_req_valid, mem_req_wen, mem_resp_valid;

  logic [2:0]  fp_req_ready, fp_resp_valid;
  logic [31:0] fp_resp_rdata, fp_mem_req_addr, fp_mem_req_wdata;
  logic        fp_resp_err, fp_mem_req_valid, fp_mem_req_wen;

  logic [31:0] addr_tb  [3];
  logic [31:0] wdata_tb [3];

  assign req_addr  = {addr_tb[2], addr_tb[1], addr_tb[0]};
  assign req_wdata = {wdata_tb[2], wdata_tb[1], wdata_tb[0]};

  always #5 clk = ~clk;

  mem_req_arbiter #(.NREQ(3), .TIMEOUT(8), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst), .halt(halt), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wen(req_wen), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_req_ready(mem_req_ready),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata)
  );

  mem_req_arbiter #(.NREQ(3), .TIMEOUT(8), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst(rst), .halt(halt), .req_valid(req_valid), .req_ready(fp_req_ready),
    .req_addr(req_addr), .req_wen(req_wen), .req_wdata(req_wdata), .resp_valid(fp_resp_valid),
    .resp_rdata(fp_resp_rdata), .resp_err(fp_resp_err), .mem_req_ready(mem_req_ready),
    .mem_req_valid(fp_mem_req_valid), .mem_req_addr(fp_mem_req_addr),
    .mem_req_wen(fp_mem_req_wen), .mem_req_wdata(fp_mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          idx;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    int          cyc;
  } gexp_t;

  typedef struct {
    logic [2:0]  onehot;
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  gexp_t mon_g;
  rexp_t mon_r;

  // Scoreboards: every handshake and every response must match the next expected entry.
  always @(negedge clk) begin
    if (mem_req_valid && mem_req_ready) begin
      if (gq.size() == 0) chk("unexpected_gnt", 64'(req_ready), 64'd0);
      else begin
        mon_g = gq.pop_front();
        chk("gnt_ready", 64'(req_ready), 64'(3'b001 << mon_g.idx));
        chk("gnt_addr", 64'(mem_req_addr), 64'(mon_g.addr));
        chk("gnt_wen", 64'(mem_req_wen), 64'(mon_g.wen));
        chk("gnt_wdata", 64'(mem_req_wdata), 64'(mon_g.wdata));
        if (mon_g.cyc >= 0) chk("gnt_cycle", 64'(cyc), 64'(mon_g.cyc));
      end
    end
    if (resp_valid != 3'b000) begin
      if (rq.size() == 0) chk("unexpected_resp", 64'(resp_valid), 64'd0);
      else begin
        mon_r = rq.pop_front();
        chk("resp_owner", 64'(resp_valid), 64'(mon_r.onehot));
        chk("resp_err", 64'(resp_err), 64'(mon_r.err));
        chk("resp_rdata", 64'(resp_rdata), 64'(mon_r.rdata));
        chk("resp_cycle", 64'(cyc), 64'(mon_r.cyc));
      end
    end
  end

  task automatic push_gnt(input int idx, input logic wen, input int at_cyc);
    gexp_t g;
    g.idx = idx; g.addr = addr_tb[idx]; g.wen = wen; g.wdata = wdata_tb[idx]; g.cyc = at_cyc;
    gq.push_back(g);
  endtask

  task automatic push_resp(input int idx, input logic err, input logic [31:0] d, input int at_cyc);
    rexp_t r;
    r.onehot = 3'b001 << idx; r.err = err; r.rdata = d; r.cyc = at_cyc;
    rq.push_back(r);
  endtask

  // Returns at the negedge of the cycle where requester idx is accepted.
  task automatic wait_hs(input int idx);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (req_ready[idx]) seen = 1'b1;
    end
    chk("handshake_seen", 64'(seen), 64'd1);
  endtask

  task automatic do_read(input int idx, input int delay, input logic [31:0] d, input logic hlt);
    push_gnt(idx, 1'b0, -1);
    req_wen[idx]   = 1'b0;
    req_valid      = '0;
    req_valid[idx] = 1'b1;
    wait_hs(idx);
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
    if (hlt) halt = 1'b1;
    repeat (delay) @(posedge clk);
    if (delay > 0) #1;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = d;
    push_resp(idx, 1'b0, d, cyc + 1);
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    logic [2:0] valid;
    logic       halt;
    logic       rdy;
    logic       exp_mvalid;
    logic [2:0] exp_ready;
    int         exp_gnt;
  } vec_t;

  vec_t vt[14];
  int   hc;

  initial begin
    // Writes only, so every accepted row stays in IDLE and only rotates the pointer.
    vt[0]  = '{3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 0};
    vt[1]  = '{3'b110, 1'b0, 1'b0, 1'b1, 3'b000, 1};
    vt[2]  = '{3'b110, 1'b1, 1'b1, 1'b0, 3'b000, 1};
    vt[3]  = '{3'b110, 1'b0, 1'b1, 1'b1, 3'b010, 1};
    vt[4]  = '{3'b110, 1'b0, 1'b0, 1'b1, 3'b000, 2};
    vt[5]  = '{3'b011, 1'b0, 1'b1, 1'b1, 3'b001, 0};
    vt[6]  = '{3'b101, 1'b0, 1'b1, 1'b1, 3'b100, 2};
    for (int i = 7; i < 12; i++) vt[i] = '{3'b111, 1'b0, 1'b0, 1'b1, 3'b000, 0};
    vt[12] = '{3'b111, 1'b0, 1'b1, 1'b1, 3'b001, 0};
    vt[13] = '{3'b111, 1'b0, 1'b1, 1'b1, 3'b010, 1};

    rst = 1'b1; halt = 1'b0; req_valid = 3'b111; req_wen = 3'b000;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    addr_tb[REQ_IFETCH] = 32'h0000_0040; wdata_tb[REQ_IFETCH] = 32'h1111_0000;
    addr_tb[REQ_DATA]   = 32'h0000_0100; wdata_tb[REQ_DATA]   = 32'h2222_0000;
    addr_tb[REQ_DEBUG]  = 32'h0000_0200; wdata_tb[REQ_DEBUG]  = 32'h3333_0000;

    // Reset held with every requester valid.
    repeat (2) @(negedge clk);
    chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = '0; req_wen = 3'b111;

    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      req_valid = vt[i].valid; halt = vt[i].halt; mem_req_ready = vt[i].rdy;
      if (vt[i].exp_ready != 3'b000) push_gnt(vt[i].exp_gnt, 1'b1, -1);
      @(negedge clk);
      chk($sformatf("vec%0d_mem_req_valid", i), 64'(mem_req_valid), 64'(vt[i].exp_mvalid));
      chk($sformatf("vec%0d_req_ready", i), 64'(req_ready), 64'(vt[i].exp_ready));
      if (vt[i].exp_mvalid)
        chk($sformatf("vec%0d_addr", i), 64'(mem_req_addr), 64'(addr_tb[vt[i].exp_gnt]));
    end
    @(posedge clk); #1;
    req_valid = '0; halt = 1'b0; mem_req_ready = 1'b1;

    // Single read from the data side.
    do_read(REQ_DATA, 3, 32'hDEAD_BEEF, 1'b0);

    // Write completes at the handshake; the ifetch read is accepted on the very next cycle.
    addr_tb[REQ_DATA] = 32'h0000_2000; wdata_tb[REQ_DATA] = 32'h0000_0055;
    req_wen[REQ_DATA] = 1'b1;
    push_gnt(REQ_DATA, 1'b1, -1);
    req_valid = 3'b010;
    wait_hs(REQ_DATA);
    hc = cyc;
    @(posedge clk); #1;
    req_valid = 3'b001; req_wen[REQ_IFETCH] = 1'b0;
    push_gnt(REQ_IFETCH, 1'b0, hc + 1);
    wait_hs(REQ_IFETCH);
    @(posedge clk); #1;
    req_valid = '0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1234_5678;
    push_resp(REQ_IFETCH, 1'b0, 32'h1234_5678, cyc + 1);
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;

    // Back-to-back reads from all three: round-robin order vs. fixed-priority instance.
    pulse_reset();
    addr_tb[REQ_DATA] = 32'h0000_0100; req_wen = 3'b000;
    for (int i = 0; i < 6; i++) push_gnt(i % 3, 1'b0, -1);
    req_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      wait_hs(i % 3);
      if (i < 3) chk($sformatf("fixed_prio_gnt%0d", i), 64'(fp_req_ready), 64'd1);
      @(posedge clk); #1;
      if (i == 5) req_valid = '0;
      mem_resp_valid = 1'b1; mem_resp_rdata = 32'hC0DE_0000 + 32'(i);
      push_resp(i % 3, 1'b0, 32'hC0DE_0000 + 32'(i), cyc + 1);
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
    end

    // Watchdog: no memory response, error 9 cycles after the handshake; a late response is dropped.
    push_gnt(REQ_DEBUG, 1'b0, -1);
    req_valid = 3'b100;
    wait_hs(REQ_DEBUG);
    hc = cyc;
    push_resp(REQ_DEBUG, 1'b1, 32'h0, hc + 9);
    @(posedge clk); #1;
    req_valid = '0;
    for (int k = 0; k < 30 && cyc < hc + 12; k++) @(posedge clk);
    #1;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Halt raised mid-read: the read completes, then nothing further is offered.
    do_read(REQ_IFETCH, 2, 32'hA5A5_0001, 1'b1);
    req_valid = 3'b111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("halt_mem_req_valid", 64'(mem_req_valid), 64'd0);
      chk("halt_req_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1;
    req_valid = '0; halt = 1'b0;
    repeat (3) @(posedge clk);

    chk("gnt_queue_drained", 64'(gq.size()), 64'd0);
    chk("resp_queue_drained", 64'(rq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
